// File: rtl/motion_arbiter_if.sv
// Motion request / wheel command bundle between the core FSM and the arbiter.
// The arbiter connects through the slave modport and the core through master.
interface motion_arbiter_if;
  logic       en_tracking;
  logic       en_uturn;
  logic       en_brake;
  logic       en_reverse;
  logic [7:0] track_duty_l;
  logic [7:0] track_duty_r;
  logic       line_centre;
  logic [1:0] wheel_mode_l;
  logic [1:0] wheel_mode_r;
  logic [7:0] duty_l;
  logic [7:0] duty_r;
  logic       brake_finished;
  logic       reverse_finished;
  logic       uturn_finished;
  logic       uturn_timeout;

  modport master (
    output en_tracking, en_uturn, en_brake, en_reverse,
    output track_duty_l, track_duty_r, line_centre,
    input  wheel_mode_l, wheel_mode_r, duty_l, duty_r,
    input  brake_finished, reverse_finished, uturn_finished, uturn_timeout
  );

  modport slave (
    input  en_tracking, en_uturn, en_brake, en_reverse,
    input  track_duty_l, track_duty_r, line_centre,
    output wheel_mode_l, wheel_mode_r, duty_l, duty_r,
    output brake_finished, reverse_finished, uturn_finished, uturn_timeout
  );
endinterface

// File: rtl/motion_arbiter.sv
// Arbitrates core motion requests into per-wheel mode/duty commands, times the
// brake/reverse/u-turn manoeuvres and inserts coast dead-time between modes.
//
// state   | meaning
// IDLE    | no live request, both wheels coast at duty 0
// DEAD    | coast dead-time before entering target_q
// TRACK   | both wheels forward at the line-tracker duties
// UTURN   | spin in place (left rev, right fwd) until line or timeout
// BRAKE   | short-brake both wheels for BRAKE_CYCLES
// REVERSE | both wheels reverse for REVERSE_CYCLES
module motion_arbiter #(
  parameter int         CNT_W            = 26,
  parameter int         DEAD_CYCLES      = 50000,
  parameter int         BRAKE_CYCLES     = 25000000,
  parameter int         REVERSE_CYCLES   = 25000000,
  parameter int         UTURN_MIN_CYCLES = 15000000,
  parameter int         UTURN_MAX_CYCLES = 50000000,
  parameter logic [7:0] UTURN_DUTY       = 8'd160,
  parameter logic [7:0] REVERSE_DUTY     = 8'd120
) (
  input logic             clk,
  input logic             rst,
  motion_arbiter_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEAD    = 3'd1;
  localparam logic [2:0] ST_TRACK   = 3'd2;
  localparam logic [2:0] ST_UTURN   = 3'd3;
  localparam logic [2:0] ST_BRAKE   = 3'd4;
  localparam logic [2:0] ST_REVERSE = 3'd5;

  localparam logic [1:0] M_COAST = 2'b00;
  localparam logic [1:0] M_FWD   = 2'b01;
  localparam logic [1:0] M_REV   = 2'b10;
  localparam logic [1:0] M_BRAKE = 2'b11;

  localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(REVERSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] UT_MIN     = CNT_W'(UTURN_MIN_CYCLES);
  localparam logic [CNT_W-1:0] UT_LAST    = CNT_W'(UTURN_MAX_CYCLES - 1);
  localparam logic [CNT_W:0]   DEAD_N     = (CNT_W + 1)'(DEAD_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [2:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]   cnt_p1;
  logic             brake_done_q, brake_done_d;
  logic             rev_done_q, rev_done_d;
  logic             ut_done_q, ut_done_d;
  logic             ut_tmo_q, ut_tmo_d;
  logic [1:0]       mode_l_q, mode_l_d, mode_r_q, mode_r_d;
  logic [7:0]       duty_l_q, duty_l_d, duty_r_q, duty_r_d;

  logic brake_cmp, rev_cmp, ut_act, ut_line, ut_tmo_hit;
  logic [2:0] winner;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_p1  = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  // Completion only counts while the request is still asserted.
  assign brake_cmp  = (state_q == ST_BRAKE)   && bus.en_brake   && (cnt_q == BRAKE_LAST);
  assign rev_cmp    = (state_q == ST_REVERSE) && bus.en_reverse && (cnt_q == REV_LAST);
  assign ut_act     = (state_q == ST_UTURN)   && bus.en_uturn;
  assign ut_line    = ut_act && (cnt_q >= UT_MIN) && bus.line_centre;
  assign ut_tmo_hit = ut_act && (cnt_q == UT_LAST) && !ut_line;

  assign brake_done_d = bus.en_brake   && (brake_done_q || brake_cmp);
  assign rev_done_d   = bus.en_reverse && (rev_done_q   || rev_cmp);
  assign ut_done_d    = bus.en_uturn   && (ut_done_q    || ut_line || ut_tmo_hit);
  assign ut_tmo_d     = ut_tmo_hit;

  // Re-arbitrate with any request that completes this cycle already retired.
  always_comb begin
    winner = ST_IDLE;
    if (bus.en_brake && !brake_done_d)        winner = ST_BRAKE;
    else if (bus.en_reverse && !rev_done_d)   winner = ST_REVERSE;
    else if (bus.en_uturn && !ut_done_d)      winner = ST_UTURN;
    else if (bus.en_tracking)                 winner = ST_TRACK;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_inc;
    if (winner == ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (winner == ST_BRAKE) begin
      if (state_q != ST_BRAKE) begin
        state_d = ST_BRAKE;
        cnt_d   = '0;
      end
    end else if (state_q == ST_DEAD) begin
      target_d = winner;
      if (cnt_p1 >= DEAD_N) begin
        state_d = winner;
        cnt_d   = '0;
      end
    end else if (state_q != winner) begin
      state_d  = ST_DEAD;
      target_d = winner;
      cnt_d    = '0;
    end
  end

  always_comb begin
    mode_l_d = M_COAST;
    mode_r_d = M_COAST;
    duty_l_d = 8'd0;
    duty_r_d = 8'd0;
    case (state_d)
      ST_TRACK: begin
        mode_l_d = M_FWD;
        mode_r_d = M_FWD;
        duty_l_d = bus.track_duty_l;
        duty_r_d = bus.track_duty_r;
      end
      ST_UTURN: begin
        mode_l_d = M_REV;
        mode_r_d = M_FWD;
        duty_l_d = UTURN_DUTY;
        duty_r_d = UTURN_DUTY;
      end
      ST_BRAKE: begin
        mode_l_d = M_BRAKE;
        mode_r_d = M_BRAKE;
        duty_l_d = 8'd255;
        duty_r_d = 8'd255;
      end
      ST_REVERSE: begin
        mode_l_d = M_REV;
        mode_r_d = M_REV;
        duty_l_d = REVERSE_DUTY;
        duty_r_d = REVERSE_DUTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      target_q     <= ST_IDLE;
      cnt_q        <= '0;
      brake_done_q <= 1'b0;
      rev_done_q   <= 1'b0;
      ut_done_q    <= 1'b0;
      ut_tmo_q     <= 1'b0;
      mode_l_q     <= M_COAST;
      mode_r_q     <= M_COAST;
      duty_l_q     <= 8'd0;
      duty_r_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      brake_done_q <= brake_done_d;
      rev_done_q   <= rev_done_d;
      ut_done_q    <= ut_done_d;
      ut_tmo_q     <= ut_tmo_d;
      mode_l_q     <= mode_l_d;
      mode_r_q     <= mode_r_d;
      duty_l_q     <= duty_l_d;
      duty_r_q     <= duty_r_d;
    end
  end

  assign bus.wheel_mode_l     = mode_l_q;
  assign bus.wheel_mode_r     = mode_r_q;
  assign bus.duty_l           = duty_l_q;
  assign bus.duty_r           = duty_r_q;
  assign bus.brake_finished   = brake_done_q;
  assign bus.reverse_finished = rev_done_q;
  assign bus.uturn_finished   = ut_done_q;
  assign bus.uturn_timeout    = ut_tmo_q;

endmodule

// File: tb/tb_motion_arbiter.sv
// Scenario bench for motion_arbiter with small timing parameters; expectations
// are queued when stimulus is applied and consumed as outputs are observed.
module tb_motion_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  motion_arbiter_if bus();

  motion_arbiter #(
    .DEAD_CYCLES(4), .BRAKE_CYCLES(10), .REVERSE_CYCLES(8),
    .UTURN_MIN_CYCLES(6), .UTURN_MAX_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;
  int   k;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] pack(input logic [1:0] ml, input logic [1:0] mr,
                                       input logic [7:0] dl, input logic [7:0] dr);
    return {12'd0, ml, mr, dl, dr};
  endfunction

  function automatic logic [31:0] outs();
    return pack(bus.wheel_mode_l, bus.wheel_mode_r, bus.duty_l, bus.duty_r);
  endfunction

  function automatic logic [31:0] flags();
    return {29'd0, bus.brake_finished, bus.reverse_finished, bus.uturn_finished};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of consecutive samples, starting with the current one, with left mode m.
  task automatic count_run(input logic [1:0] m, output int cnt);
    cnt = 0;
    while (bus.wheel_mode_l === m && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic drop_all();
    bus.en_tracking = 1'b0;
    bus.en_uturn    = 1'b0;
    bus.en_brake    = 1'b0;
    bus.en_reverse  = 1'b0;
  endtask

  initial begin
    drop_all();
    bus.track_duty_l = 8'd0;
    bus.track_duty_r = 8'd0;
    bus.line_centre  = 1'b0;

    // Reset state
    #12;
    sb_push("rst_outs", 32'd0);
    sb_push("rst_flags", 32'd0);
    sb_push("rst_tmo", 32'd0);
    sb_pop(outs());
    sb_pop(flags());
    sb_pop({31'd0, bus.uturn_timeout});
    rst = 1'b1;
    tick();

    // 1: tracking from IDLE
    bus.track_duty_l = 8'd90;
    bus.track_duty_r = 8'd70;
    bus.en_tracking  = 1'b1;
    sb_push("trk_dead_cycles", 32'd4);
    sb_push("trk_outs", pack(2'b01, 2'b01, 8'd90, 8'd70));
    sb_push("trk_duty_hold", 32'd90);
    sb_push("trk_duty_new", 32'd100);
    tick();
    count_run(2'b00, n);
    sb_pop(32'(n));
    sb_pop(outs());
    bus.track_duty_l = 8'd100;
    #1;
    sb_pop({24'd0, bus.duty_l});
    tick();
    sb_pop({24'd0, bus.duty_l});

    // 2: brake pre-empts tracking with no dead-time
    bus.en_brake = 1'b1;
    sb_push("brk_outs", pack(2'b11, 2'b11, 8'd255, 8'd255));
    sb_push("brk_cycles", 32'd10);
    sb_push("brk_finished", 32'b100);
    sb_push("brk_finished_hold", 32'b100);
    sb_push("brk_flags_clear", 32'd0);
    tick();
    sb_pop(outs());
    count_run(2'b11, n);
    sb_pop(32'(n));
    sb_pop(flags());
    repeat (3) tick();
    sb_pop(flags());
    drop_all();
    tick();
    sb_pop(flags());

    // 3: brake then u-turn completed by the line sensor
    bus.en_brake = 1'b1;
    bus.en_uturn = 1'b1;
    sb_push("bu_brake_cycles", 32'd10);
    sb_push("bu_dead_cycles", 32'd4);
    sb_push("bu_ut_outs", pack(2'b10, 2'b01, 8'd160, 8'd160));
    sb_push("bu_line_count", 32'd7);
    sb_push("bu_after_outs", 32'd0);
    sb_push("bu_flags", 32'b101);
    sb_push("bu_tmo", 32'd0);
    tick();
    count_run(2'b11, n);
    sb_pop(32'(n));
    count_run(2'b00, n);
    sb_pop(32'(n));
    sb_pop(outs());
    k = 0;
    while (k < 50) begin
      bus.line_centre = (k == 3 || k == 7);
      tick();
      if (bus.uturn_finished) break;
      k++;
    end
    bus.line_centre = 1'b0;
    sb_pop(32'(k));
    sb_pop(outs());
    sb_pop(flags());
    sb_pop({31'd0, bus.uturn_timeout});
    drop_all();
    tick();

    // 4: u-turn timeout
    bus.en_uturn = 1'b1;
    sb_push("tmo_dead_cycles", 32'd4);
    sb_push("tmo_spin_cycles", 32'd20);
    sb_push("tmo_finished", 32'b001);
    sb_push("tmo_pulse_hi", 32'd1);
    sb_push("tmo_pulse_lo", 32'd0);
    tick();
    count_run(2'b00, n);
    sb_pop(32'(n));
    count_run(2'b10, n);
    sb_pop(32'(n));
    sb_pop(flags());
    sb_pop({31'd0, bus.uturn_timeout});
    tick();
    sb_pop({31'd0, bus.uturn_timeout});

    // 5: reverse with u-turn still retired
    bus.en_reverse = 1'b1;
    sb_push("rev_dead_cycles", 32'd4);
    sb_push("rev_outs", pack(2'b10, 2'b10, 8'd120, 8'd120));
    sb_push("rev_cycles", 32'd8);
    sb_push("rev_flags", 32'b011);
    sb_push("rev_idle_outs", 32'd0);
    sb_push("rev_flags_clear", 32'd0);
    tick();
    count_run(2'b00, n);
    sb_pop(32'(n));
    sb_pop(outs());
    count_run(2'b10, n);
    sb_pop(32'(n));
    sb_pop(flags());
    sb_pop(outs());
    drop_all();
    tick();
    sb_pop(flags());

    // 6: reset in the middle of a reverse
    bus.en_reverse = 1'b1;
    sb_push("rr_dead_cycles", 32'd4);
    sb_push("rr_mid_outs", pack(2'b10, 2'b10, 8'd120, 8'd120));
    sb_push("rr_rst_outs", 32'd0);
    sb_push("rr_rst_flags", 32'd0);
    sb_push("rr_dead2_cycles", 32'd4);
    sb_push("rr_rev2_cycles", 32'd8);
    sb_push("rr_finished", 32'b010);
    tick();
    count_run(2'b00, n);
    sb_pop(32'(n));
    repeat (3) tick();
    sb_pop(outs());
    rst = 1'b0;
    #1;
    sb_pop(outs());
    sb_pop(flags());
    #1;
    rst = 1'b1;
    tick();
    count_run(2'b00, n);
    sb_pop(32'(n));
    count_run(2'b10, n);
    sb_pop(32'(n));
    sb_pop(flags());
    drop_all();
    tick();

    check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
